jtdsp16_prom: RTL and testbench
===============================

Name: jtdsp16_prom

Overview:
Parametrised program memory for the DSP16 core.
- Serves PC instruction fetch from internal memory.
- Serves PT-pointer data reads from internal memory or from external memory over a request/acknowledge handshake with timeout.
- Accepts a byte-wide programming stream with an auto-incrementing address.
- Sits between the sequencer (PC/PT) and the external ROM bus.

Parameters:
AW, 12, internal word-address bits; internal size is 2^AW words; legal range 8..15.
DW, 16, word width; must be a multiple of 8, range 8..32.
TOUT, 255, clk cycles allowed for ext_ok before an external read aborts; minimum 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cen  in  1  clock enable; gates pt_load sampling only
addr  in  16  PC fetch address
dout  out  DW  PC fetch data
pt  in  16  PT read address
pt_load  in  1  PT read request, sampled when cen=1
pt_dout  out  DW  PT read data, registered
pt_busy  out  1  PT read in progress; sequencer stalls while high
ext_rq  out  1  external read request
ext_addr  out  16  external read address
ext_data  in  DW  external read data
ext_ok  in  1  external acknowledge, data valid this cycle
ext_err  out  1  sticky: an external read timed out
prog_start  in  1  clears programming address and byte lane
prog_data  in  8  programming byte
prog_we  in  1  programming byte strobe
prog_wrap  out  1  sticky: programming address wrapped past 2^AW-1

Behaviour:
- Reset (rst=1 at posedge):
  - FSM goes to IDLE.
  - ext_rq=0, ext_addr=0, pt_busy=0, pt_dout=0, ext_err=0, prog_wrap=0.
  - Programming address=0, byte lane=0, timeout counter=0.
  - Memory contents are kept. dout is not reset.
- PC port:
  - dout <= mem[addr[AW-1:0]] every clk, independent of cen. One-cycle latency.
  - addr[15:AW] is ignored (aliases).
- PT FSM states: IDLE, EXT.
  - IDLE, pt_load&cen, pt[15:AW]==0: internal read. pt_dout = mem[pt[AW-1:0]] after 1 clk. pt_busy stays 0.
  - IDLE, pt_load&cen, pt[15:AW]!=0: go to EXT. ext_rq=1, ext_addr=pt (latched), pt_busy=1, counter cleared.
  - EXT, ext_ok=1 (any clk, cen ignored): pt_dout<=ext_data. ext_rq, pt_busy and ext_addr clear at that same edge. Return to IDLE.
  - EXT, counter reaches TOUT-1 without ext_ok: pt_dout<={DW{1'b1}}, ext_err<=1. Release the bus and return to IDLE.
  - pt_load while pt_busy=1 is ignored.
  - ext_ok outside EXT is ignored.
  - ext_addr=0 whenever ext_rq=0.
- Programming:
  - Bytes arrive LSB first into a DW-bit assembly register.
  - Byte lane counts 0..DW/8-1.
  - On the prog_we that fills the last lane, the word is written to mem[prog address]. The address then increments and the lane returns to 0.
  - Address DW wraps from 2^AW-1 to 0 and sets prog_wrap.
  - prog_start clears address and lane and discards the partial word. prog_start together with prog_we: the clear applies first, then the byte goes into lane 0.
- Write/read conflict:
  - The word write and an internal PT read share one memory port. The write has priority.
  - An internal PT read requested in the write cycle is held. pt_busy=1 for exactly one cycle, the read completes one cycle later, and it returns post-write data if the address matches.
- Read-during-write on the PC port to the same address returns old data.
- Reset mid-EXT: ext_rq drops at the reset edge; ext_data and ext_ok are ignored.

Optional Feature:
JTDSP16_PROM_CACHE_EN:
- Defined: a one-entry external cache holds a tag (ext_addr), data and a valid bit.
  - On a successful EXT completion, the tag and data are loaded and valid=1.
  - On pt_load to an external address equal to the tag with valid=1: pt_dout=cached data after 1 clk, pt_busy=0, no ext_rq.
  - Timeout does not fill the cache. rst clears valid.
- Undefined: every external PT read issues ext_rq.

Test Plan:
- Program bytes 34,12,78,56 (DW=16) after prog_start -> mem[0]=1234, mem[1]=5678; PC addr=1 -> dout=5678 one clk later.
- pt=0001, pt_load, cen -> pt_dout=5678 next clk; pt_busy never high; ext_rq never high.
- pt=4000, pt_load; ext_ok 3 clks later with ext_data=ABCD -> ext_addr=4000 while ext_rq; pt_busy high 3 cycles; pt_dout=ABCD; ext_rq low after the ack edge.
- pt=8000, no ext_ok, TOUT=8 -> release after 8 clks; pt_dout=FFFF; ext_err=1 until rst.
- AW=8: write 257 words -> prog_wrap=1; mem[0] holds word 256; prog_start mid-word -> partial byte discarded.
- Internal pt_load coinciding with the final prog_we to the same address -> pt_busy high 1 cycle; pt_dout returns the new word. Under JTDSP16_PROM_CACHE_EN, a repeated pt=4000 after ack -> no ext_rq, pt_dout=ABCD in 1 clk.

Source files
------------

// File: rtl/jtdsp16_prom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtdsp16_prom: DSP16 program memory, PC fetch, PT reads (internal/external) |
// | and byte-wide programming. Optional macro: JTDSP16_PROM_CACHE_EN.           |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module jtdsp16_prom #(
  parameter int AW   = 12,
  parameter int DW   = 16,
  parameter int TOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [15:0]   addr,
  output logic [DW-1:0] dout,
  input  logic [15:0]   pt,
  input  logic          pt_load,
  output logic [DW-1:0] pt_dout,
  output logic          pt_busy,
  output logic          ext_rq,
  output logic [15:0]   ext_addr,
  input  logic [DW-1:0] ext_data,
  input  logic          ext_ok,
  output logic          ext_err,
  input  logic          prog_start,
  input  logic [7:0]    prog_data,
  input  logic          prog_we,
  output logic          prog_wrap
);

  localparam int LANES = DW / 8;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW    = (TOUT > 2) ? $clog2(TOUT) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TOUT - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_EXT = 1'b1} state_t;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] dout_q;

  state_t        state_q, state_d;
  logic [15:0]   ext_addr_q, ext_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] pt_dout_q, pt_dout_d;
  logic          ext_err_q, ext_err_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] asm_q, asm_d;
  logic          wrap_q, wrap_d;

  logic [LW-1:0] lane_b;
  logic [AW-1:0] paddr_b;
  logic          wr_en;
  logic          cache_hit;
  logic [DW-1:0] cache_data;

  always_ff @(posedge clk) begin
    if (wr_en) mem[paddr_b] <= asm_d;
    dout_q <= mem[addr[AW-1:0]];
  end

  always_comb begin
    state_d     = state_q;
    ext_addr_d  = ext_addr_q;
    cnt_d       = cnt_q;
    pt_dout_d   = pt_dout_q;
    ext_err_d   = ext_err_q;
    pend_d      = 1'b0;
    pend_addr_d = pend_addr_q;
    wrap_d      = wrap_q;
    wr_en       = 1'b0;

    // prog_start wins over the stored lane/address so a simultaneous byte lands in lane 0
    lane_b  = prog_start ? '0 : lane_q;
    paddr_b = prog_start ? '0 : paddr_q;
    asm_d   = prog_start ? '0 : asm_q;
    lane_d  = lane_b;
    paddr_d = paddr_b;
    if (prog_we) begin
      asm_d[{lane_b, 3'b000} +: 8] = prog_data;
      if (lane_b == LAST_LANE) begin
        wr_en   = !rst;
        lane_d  = '0;
        paddr_d = paddr_b + AW'(1);
        if (paddr_b == '1) wrap_d = 1'b1;
      end else begin
        lane_d = lane_b + LW'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pt_dout_d = mem[pend_addr_q];
        end else if (pt_load && cen) begin
          if (pt[15:AW] == '0) begin
            // The programming write owns the port this cycle; retry the read next cycle
            if (wr_en) begin
              pend_d      = 1'b1;
              pend_addr_d = pt[AW-1:0];
            end else begin
              pt_dout_d = mem[pt[AW-1:0]];
            end
          end else if (cache_hit) begin
            pt_dout_d = cache_data;
          end else begin
            state_d    = S_EXT;
            ext_addr_d = pt;
            cnt_d      = '0;
          end
        end
      end
      S_EXT: begin
        if (ext_ok) begin
          pt_dout_d  = ext_data;
          state_d    = S_IDLE;
          ext_addr_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          pt_dout_d  = '1;
          ext_err_d  = 1'b1;
          state_d    = S_IDLE;
          ext_addr_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ext_addr_q  <= '0;
      cnt_q       <= '0;
      pt_dout_q   <= '0;
      ext_err_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      lane_q      <= '0;
      paddr_q     <= '0;
      asm_q       <= '0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_addr_q  <= ext_addr_d;
      cnt_q       <= cnt_d;
      pt_dout_q   <= pt_dout_d;
      ext_err_q   <= ext_err_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      lane_q      <= lane_d;
      paddr_q     <= paddr_d;
      asm_q       <= asm_d;
      wrap_q      <= wrap_d;
    end
  end

`ifdef JTDSP16_PROM_CACHE_EN
  logic          cv_q;
  logic [15:0]   ctag_q;
  logic [DW-1:0] cdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cv_q    <= 1'b0;
      ctag_q  <= '0;
      cdata_q <= '0;
    end else if (state_q == S_EXT && ext_ok) begin
      cv_q    <= 1'b1;
      ctag_q  <= ext_addr_q;
      cdata_q <= ext_data;
    end
  end

  assign cache_hit  = cv_q && (ctag_q == pt);
  assign cache_data = cdata_q;
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  assign dout      = dout_q;
  assign pt_dout   = pt_dout_q;
  assign pt_busy   = (state_q == S_EXT) || pend_q;
  assign ext_rq    = (state_q == S_EXT);
  assign ext_addr  = ext_addr_q;
  assign ext_err   = ext_err_q;
  assign prog_wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_jtdsp16_prom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_jtdsp16_prom: directed bench for jtdsp16_prom (AW=8, DW=16, TOUT=8).     |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_jtdsp16_prom;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int TOUT = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b0;
  logic [15:0]   addr = '0;
  logic [DW-1:0] dout;
  logic [15:0]   pt = '0;
  logic          pt_load = 1'b0;
  logic [DW-1:0] pt_dout;
  logic          pt_busy;
  logic          ext_rq;
  logic [15:0]   ext_addr;
  logic [DW-1:0] ext_data = '0;
  logic          ext_ok = 1'b0;
  logic          ext_err;
  logic          prog_start = 1'b0;
  logic [7:0]    prog_data = '0;
  logic          prog_we = 1'b0;
  logic          prog_wrap;

  int n_tests = 0;
  int n_fail  = 0;

  jtdsp16_prom #(.AW(AW), .DW(DW), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .cen(cen), .addr(addr), .dout(dout),
    .pt(pt), .pt_load(pt_load), .pt_dout(pt_dout), .pt_busy(pt_busy),
    .ext_rq(ext_rq), .ext_addr(ext_addr), .ext_data(ext_data), .ext_ok(ext_ok),
    .ext_err(ext_err), .prog_start(prog_start), .prog_data(prog_data),
    .prog_we(prog_we), .prog_wrap(prog_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b, input logic start);
    prog_we    = 1'b1;
    prog_data  = b;
    prog_start = start;
    tick();
    prog_we    = 1'b0;
    prog_start = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    logic [15:0] w;

    // Reset
    tick(); tick();
    check("rst_ext_rq", ext_rq, 0);
    check("rst_ext_addr", ext_addr, 0);
    check("rst_pt_busy", pt_busy, 0);
    check("rst_pt_dout", pt_dout, 0);
    check("rst_ext_err", ext_err, 0);
    check("rst_prog_wrap", prog_wrap, 0);
    rst = 1'b0;

    // Programming two words, LSB first
    put_byte(8'h34, 1'b1);
    put_byte(8'h12, 1'b0);
    put_byte(8'h78, 1'b0);
    put_byte(8'h56, 1'b0);
    addr = 16'h0000; tick();
    check("pc_mem0", dout, 16'h1234);
    addr = 16'h0001; tick();
    check("pc_mem1", dout, 16'h5678);
    addr = 16'hFF01; tick();
    check("pc_alias", dout, 16'h5678);

    // Internal PT read
    pt = 16'h0001; pt_load = 1'b1; cen = 1'b1; tick(); pt_load = 1'b0;
    check("int_pt_dout", pt_dout, 16'h5678);
    check("int_pt_busy", pt_busy, 0);
    check("int_ext_rq", ext_rq, 0);
    pt = 16'h0000; pt_load = 1'b1; cen = 1'b0; tick(); pt_load = 1'b0; cen = 1'b1;
    check("cen_gates_load", pt_dout, 16'h5678);

    // External PT read, ack on the third edge
    pt = 16'h4000; pt_load = 1'b1; tick(); pt_load = 1'b0;
    check("ext_rq_up", ext_rq, 1);
    check("ext_addr_latch", ext_addr, 16'h4000);
    check("ext_busy_c1", pt_busy, 1);
    pt = 16'h0000; pt_load = 1'b1; tick(); pt_load = 1'b0;
    check("load_while_busy", pt_dout, 16'h5678);
    check("ext_busy_c2", pt_busy, 1);
    tick();
    check("ext_busy_c3", pt_busy, 1);
    ext_ok = 1'b1; ext_data = 16'hABCD; tick(); ext_ok = 1'b0;
    check("ext_pt_dout", pt_dout, 16'hABCD);
    check("ext_rq_down", ext_rq, 0);
    check("ext_busy_down", pt_busy, 0);
    check("ext_addr_clr", ext_addr, 0);
    ext_ok = 1'b1; ext_data = 16'h1111; tick(); ext_ok = 1'b0;
    check("stray_ack", pt_dout, 16'hABCD);

    // Repeat external read of the same address
    pt = 16'h4000; pt_load = 1'b1; tick(); pt_load = 1'b0;
`ifdef JTDSP16_PROM_CACHE_EN
    check("cache_no_rq", ext_rq, 0);
    check("cache_no_busy", pt_busy, 0);
    check("cache_pt_dout", pt_dout, 16'hABCD);
`else
    check("nocache_rq", ext_rq, 1);
    ext_ok = 1'b1; ext_data = 16'hABCD; tick(); ext_ok = 1'b0;
    check("nocache_pt_dout", pt_dout, 16'hABCD);
`endif

    // Timeout
    pt = 16'h8000; pt_load = 1'b1; tick(); pt_load = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 20 && pt_busy; k++) begin
      busy_cnt++;
      tick();
    end
    check("to_busy_cycles", busy_cnt, 8);
    check("to_pt_dout", pt_dout, 16'hFFFF);
    check("to_ext_err", ext_err, 1);
    check("to_ext_rq", ext_rq, 0);

    // Timed-out address is fetched again over the bus
    pt = 16'h8000; pt_load = 1'b1; tick(); pt_load = 1'b0;
    check("after_to_rq", ext_rq, 1);
    ext_ok = 1'b1; ext_data = 16'h2468; tick(); ext_ok = 1'b0;
    check("after_to_dout", pt_dout, 16'h2468);

    // Write/read conflict plus PC read-during-write
    put_byte(8'hEF, 1'b1);
    prog_we = 1'b1; prog_data = 8'hBE; pt = 16'h0000; pt_load = 1'b1; addr = 16'h0000;
    tick();
    prog_we = 1'b0; pt_load = 1'b0;
    check("conf_busy", pt_busy, 1);
    check("conf_hold", pt_dout, 16'h2468);
    check("rdw_old", dout, 16'h1234);
    tick();
    check("conf_busy_end", pt_busy, 0);
    check("conf_pt_dout", pt_dout, 16'hBEEF);
    check("rdw_new", dout, 16'hBEEF);
    check("ext_err_sticky", ext_err, 1);

    // Address wrap with AW=8
    for (int i = 0; i < 257; i++) begin
      w = 16'(i * 3 + 16'h1000);
      put_byte(w[7:0], i == 0);
      put_byte(w[15:8], 1'b0);
      if (i == 254) check("wrap_before", prog_wrap, 0);
      if (i == 255) check("wrap_set", prog_wrap, 1);
    end
    addr = 16'h0000; tick();
    check("wrap_mem0", dout, 16'h1300);
    addr = 16'h0001; tick();
    check("wrap_mem1", dout, 16'h1003);

    // prog_start discards a partial word
    put_byte(8'h11, 1'b1);
    put_byte(8'h22, 1'b1);
    put_byte(8'h33, 1'b0);
    addr = 16'h0000; tick();
    check("discard_mem0", dout, 16'h3322);
    check("wrap_sticky", prog_wrap, 1);

    // Reset in the middle of an external read
    pt = 16'h8000; pt_load = 1'b1; tick(); pt_load = 1'b0;
    check("mid_rq", ext_rq, 1);
    rst = 1'b1; ext_ok = 1'b1; ext_data = 16'h5555; tick();
    check("mid_rst_rq", ext_rq, 0);
    check("mid_rst_busy", pt_busy, 0);
    check("mid_rst_dout", pt_dout, 0);
    check("mid_rst_err", ext_err, 0);
    check("mid_rst_wrap", prog_wrap, 0);
    check("mid_rst_addr", ext_addr, 0);
    rst = 1'b0; tick(); ext_ok = 1'b0;
    check("post_rst_ack_ign", pt_dout, 0);
    addr = 16'h0001; tick();
    check("mem_kept", dout, 16'h1003);

    // Cache (if any) cleared by reset
    pt = 16'h4000; pt_load = 1'b1; tick(); pt_load = 1'b0;
    check("post_rst_rq", ext_rq, 1);
    ext_ok = 1'b1; ext_data = 16'h0F0F; tick(); ext_ok = 1'b0;
    check("post_rst_dout", pt_dout, 16'h0F0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
